axis_seq_packer: RTL

Downstream consumer for a 32-bit AXI-Stream counter source. It accepts the raw count words and checks that each word is the previous one plus 1, counting and flagging any discontinuity. It then forwards every word unchanged on an output stream framed into fixed-length packets with TLAST. It sits between the counter source and the debug/DMA path, with full backpressure in both directions.

---
 rtl/axis_dbg_pkg.sv | 19 +
 rtl/axis_skid2.sv | 61 ++++++
 rtl/axis_seq_packer.sv | 112 +++++++++++
 3 files changed

// File: rtl/axis_dbg_pkg.sv
// Shared types for the AXI-Stream debug path: data width, checker states, buffer entry.
// AXIS_SEQ_PACKER_ERR_TAG_EN adds a per-word error tag to the buffer entry.
package axis_dbg_pkg;

   localparam int AXIS_DATA_W = 32;

   typedef enum logic {SYNC, CHECK} chk_state_e;

   typedef struct packed {
      logic [AXIS_DATA_W-1:0] data;
      logic                   last;
`ifdef AXIS_SEQ_PACKER_ERR_TAG_EN
      logic                   user;
`endif
   } buf_entry_t;

   localparam int ENTRY_W = $bits(buf_entry_t);

endpackage

// File: rtl/axis_skid2.sv
// Generic 2-entry skid buffer with a registered ready; head entry drives the output.
module axis_skid2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   logic [W-1:0] head_q, head_d, tail_q, tail_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         rdy_q, rdy_d;
   logic         push, pop;

   assign push      = in_valid & rdy_q;
   assign pop       = (cnt_q != 2'd0) & out_ready;
   assign in_ready  = rdy_q;
   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = head_q;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) head_d = in_data;
            else               tail_d = in_data;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
         end
         // Push while full is impossible (ready is low), so occupancy is 1 here.
         2'b11: head_d = in_data;
         default: ;
      endcase
      rdy_d = (cnt_d < 2'd2);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= 2'd0;
         rdy_q  <= 1'b0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         rdy_q  <= rdy_d;
      end
   end

endmodule

// File: rtl/axis_seq_packer.sv
// Counter-stream sequence checker and fixed-length packetizer with TLAST framing.
// Define AXIS_SEQ_PACKER_ERR_TAG_EN to add out_TUSER marking mismatching words.
module axis_seq_packer
   import axis_dbg_pkg::*;
#(
   parameter int PKT_LEN = 16,
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [AXIS_DATA_W-1:0] in_TDATA,
   input  logic                   in_TVALID,
   output logic                   in_TREADY,
   output logic [AXIS_DATA_W-1:0] out_TDATA,
   output logic                   out_TVALID,
   input  logic                   out_TREADY,
   output logic                   out_TLAST,
   output logic                   seq_err,
   output logic [CNT_W-1:0]       err_count,
   output logic [CNT_W-1:0]       pkt_count
`ifdef AXIS_SEQ_PACKER_ERR_TAG_EN
   ,output logic                  out_TUSER
`endif
);

   localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

   chk_state_e             state_q, state_d;
   logic [AXIS_DATA_W-1:0] exp_q, exp_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   seq_err_q, seq_err_d;
   logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]       pkt_cnt_q, pkt_cnt_d;

   buf_entry_t         in_ent, out_ent;
   logic [ENTRY_W-1:0] out_vec;
   logic               in_fire, out_fire, is_last, mismatch;

   assign in_fire  = in_TVALID & in_TREADY;
   assign out_fire = out_TVALID & out_TREADY;
   assign is_last  = (idx_q == IDX_W'(PKT_LEN - 1));
   assign mismatch = in_fire && (state_q == CHECK) && (in_TDATA != exp_q);

   always_comb begin
      in_ent      = '0;
      in_ent.data = in_TDATA;
      in_ent.last = is_last;
`ifdef AXIS_SEQ_PACKER_ERR_TAG_EN
      in_ent.user = mismatch;
`endif
   end

   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      idx_d     = idx_q;
      seq_err_d = seq_err_q;
      err_cnt_d = err_cnt_q;
      pkt_cnt_d = pkt_cnt_q;
      // Every accepted word, good or bad, becomes the new reference point.
      if (in_fire) begin
         state_d = CHECK;
         exp_d   = in_TDATA + 32'd1;
         idx_d   = is_last ? '0 : idx_q + IDX_W'(1);
      end
      if (mismatch) begin
         seq_err_d = 1'b1;
         if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      if (out_fire && out_ent.last) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= SYNC;
         exp_q     <= '0;
         idx_q     <= '0;
         seq_err_q <= 1'b0;
         err_cnt_q <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         idx_q     <= idx_d;
         seq_err_q <= seq_err_d;
         err_cnt_q <= err_cnt_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   axis_skid2 #(.W(ENTRY_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_ent),
      .in_valid  (in_TVALID),
      .in_ready  (in_TREADY),
      .out_data  (out_vec),
      .out_valid (out_TVALID),
      .out_ready (out_TREADY)
   );

   assign out_ent    = buf_entry_t'(out_vec);
   assign out_TDATA  = out_ent.data;
   assign out_TLAST  = out_ent.last;
`ifdef AXIS_SEQ_PACKER_ERR_TAG_EN
   assign out_TUSER  = out_ent.user;
`endif
   assign seq_err    = seq_err_q;
   assign err_count  = err_cnt_q;
   assign pkt_count  = pkt_cnt_q;

endmodule
